// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit controller.
// The misalignment rule lives here so the FSM and its users agree on it.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  localparam logic [1:0] SZ_SW = 2'b00;
  localparam logic [1:0] SZ_SB = 2'b01;
  localparam logic [1:0] SZ_SH = 2'b10;

  localparam int TIMEOUT_CYCLES_DEF = 255;

  // Byte accesses and unknown load types never fault; the unused store code 11 is treated as a word.
  function automatic logic is_misaligned(input logic       wr,
                                         input logic [2:0] load_size,
                                         input logic [1:0] store_size,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (wr) begin
      case (store_size)
        SZ_SB:   mis = 1'b0;
        SZ_SH:   mis = addr_lo[0];
        default: mis = (addr_lo != 2'b00);
      endcase
    end else begin
      case (load_size)
        LD_LW:          mis = (addr_lo != 2'b00);
        LD_LH, LD_LHU:  mis = addr_lo[0];
        default:        mis = 1'b0;
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/lsu_ldext.sv
// Load extraction: picks the addressed byte/half from the returned word
// and sign- or zero-extends it according to the load type.
module lsu_ldext
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_size,
  output logic [31:0] ext
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lanes[addr_lo];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ext = 32'd0;
    case (load_size)
      LD_LW:   ext = rdata;
      LD_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  ext = {24'd0, byte_sel};
      LD_LH:   ext = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  ext = {16'd0, half_sel};
      default: ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: stalls the pipeline around one memory access,
// formats store lanes, extends load data and reports misalignment/timeouts.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  LoadSize,
  input  logic [1:0]  StoreSize,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] ReadDataW,
  output logic        LoadValidW,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  output logic [3:0]  DMemBE,
  input  logic        DMemAck,
  input  logic [31:0] DMemRData
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_e    state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [31:0]   addr_reg, wdata_reg, rdw_reg, ext_data, wdata_next;
  logic [2:0]    lsize_reg;
  logic [3:0]    be_reg, be_next;
  logic          wr_reg, err_reg;
  logic          misalign, accept, timeout_hit;

  assign misalign    = is_misaligned(MemWriteM, LoadSize, StoreSize, AddrM[1:0]);
  assign accept      = MemReqM && !misalign;
  // Timeout fires on the cycle the counter would reach TIMEOUT_CYCLES.
  assign timeout_hit = (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = WriteDataM;
    if (MemWriteM) begin
      case (StoreSize)
        SZ_SB: begin
          be_next    = 4'b0001 << AddrM[1:0];
          wdata_next = {4{WriteDataM[7:0]}};
        end
        SZ_SH: begin
          be_next    = 4'b0011 << {AddrM[1], 1'b0};
          wdata_next = {2{WriteDataM[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = WriteDataM;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_BUSY;
      S_BUSY:  if (DMemAck || timeout_hit) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    StallM     = 1'b0;
    MisalignM  = 1'b0;
    DMemReq    = 1'b0;
    DMemWe     = 1'b0;
    DMemBE     = 4'b0000;
    LoadValidW = 1'b0;
    BusErrM    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        StallM    = accept;
        MisalignM = MemReqM && misalign;
      end
      S_BUSY: begin
        StallM  = 1'b1;
        DMemReq = 1'b1;
        DMemWe  = wr_reg;
        DMemBE  = be_reg;
      end
      S_DONE: begin
        LoadValidW = !wr_reg && !err_reg;
        BusErrM    = err_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= '0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      rdw_reg   <= 32'd0;
      lsize_reg <= 3'd0;
      be_reg    <= 4'd0;
      wr_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            addr_reg  <= AddrM;
            wdata_reg <= wdata_next;
            lsize_reg <= LoadSize;
            be_reg    <= be_next;
            wr_reg    <= MemWriteM;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
          end
        end
        S_BUSY: begin
          if (DMemAck) begin
            rdw_reg <= wr_reg ? 32'd0 : ext_data;
            cnt_reg <= '0;
          end else if (timeout_hit) begin
            rdw_reg <= 32'd0;
            err_reg <= 1'b1;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  lsu_ldext u_ldext (
    .rdata     (DMemRData),
    .addr_lo   (addr_reg[1:0]),
    .load_size (lsize_reg),
    .ext       (ext_data)
  );

  assign ReadDataW = rdw_reg;
  assign DMemAddr  = {addr_reg[31:2], 2'b00};
  assign DMemWData = wdata_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed and random transactions checked
// against an arithmetic model of the load/store rules.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReqM, MemWriteM;
  logic [2:0]  LoadSize;
  logic [1:0]  StoreSize;
  logic [31:0] AddrM, WriteDataM;
  logic        StallM, LoadValidW, MisalignM, BusErrM, DMemReq, DMemWe;
  logic [31:0] ReadDataW, DMemAddr, DMemWData;
  logic [3:0]  DMemBE;
  logic        DMemAck;
  logic [31:0] DMemRData;

  logic        to_stall, to_lv, to_mis, to_berr, to_req, to_we;
  logic [31:0] to_rdw, to_addr, to_wdata;
  logic [3:0]  to_be;
  logic        ack_to;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .LoadSize(LoadSize), .StoreSize(StoreSize), .AddrM(AddrM), .WriteDataM(WriteDataM),
    .StallM(StallM), .ReadDataW(ReadDataW), .LoadValidW(LoadValidW), .MisalignM(MisalignM),
    .BusErrM(BusErrM), .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
    .DMemWData(DMemWData), .DMemBE(DMemBE), .DMemAck(DMemAck), .DMemRData(DMemRData)
  );

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .LoadSize(LoadSize), .StoreSize(StoreSize), .AddrM(AddrM), .WriteDataM(WriteDataM),
    .StallM(to_stall), .ReadDataW(to_rdw), .LoadValidW(to_lv), .MisalignM(to_mis),
    .BusErrM(to_berr), .DMemReq(to_req), .DMemWe(to_we), .DMemAddr(to_addr),
    .DMemWData(to_wdata), .DMemBE(to_be), .DMemAck(ack_to), .DMemRData(DMemRData)
  );

  // Access size in bytes; an access is misaligned when the address is not a multiple of it.
  function automatic bit model_misaligned(input bit wr, input logic [2:0] ls,
                                          input logic [1:0] ss, input logic [31:0] a);
    int sz;
    if (wr) sz = (ss == 2'd1) ? 1 : (ss == 2'd2) ? 2 : 4;
    else    sz = (ls == 3'd0) ? 4 : (ls == 3'd3 || ls == 3'd4) ? 2 : 1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] ls, input logic [31:0] a,
                                             input logic [31:0] rd);
    int off, b, h;
    off = int'(a % 4);
    b = int'((rd >> (8 * off)) & 32'hFF);
    h = int'((rd >> (16 * (off / 2))) & 32'hFFFF);
    case (ls)
      3'd0: return rd;
      3'd1: return 32'((b >= 128) ? b - 256 : b);
      3'd2: return 32'(b);
      3'd3: return 32'((h >= 32768) ? h - 65536 : h);
      3'd4: return 32'(h);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_store(input bit wr, input logic [1:0] ss, input logic [31:0] a,
                             input logic [31:0] wd, output logic [3:0] be, output logic [31:0] wo);
    int off;
    off = int'(a % 4);
    be = 4'hF;
    wo = wd;
    if (wr && ss == 2'd1) begin
      be = 4'(1 << off);
      wo = (wd & 32'hFF) * 32'h0101_0101;
    end else if (wr && ss == 2'd2) begin
      be = 4'(3 << (off & 2));
      wo = (wd & 32'hFFFF) * 32'h0001_0001;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; MemReqM = 1'b0; DMemAck = 1'b0; ack_to = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Call in the low clock phase with the DUT idle; returns in the idle cycle after DONE.
  task automatic do_txn(input string name, input bit wr, input logic [2:0] ls,
                        input logic [1:0] ss, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int busy);
    bit exp_mis, done;
    logic [3:0] exp_be;
    logic [31:0] exp_wd, exp_rd;
    int stalls, k;
    exp_mis = model_misaligned(wr, ls, ss, addr);
    model_store(wr, ss, addr, wd, exp_be, exp_wd);
    exp_rd = model_load(ls, addr, rd);
    MemReqM = 1'b1; MemWriteM = wr; LoadSize = ls; StoreSize = ss;
    AddrM = addr; WriteDataM = wd; DMemAck = 1'b0; DMemRData = $urandom;
    #1;
    checks++;
    if (LoadValidW !== 1'b0 || BusErrM !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_pulses: lv=%b berr=%b expected 0 0", name, LoadValidW, BusErrM);
    end
    if (exp_mis) begin
      checks++;
      if (MisalignM !== 1'b1 || StallM !== 1'b0 || DMemReq !== 1'b0) begin
        failures++;
        $display("FAIL %s misalign: mis=%b stall=%b req=%b expected 1 0 0", name, MisalignM, StallM, DMemReq);
      end
      @(negedge clk);
      MemReqM = 1'b0;
      #1;
      checks++;
      if (MisalignM !== 1'b0 || StallM !== 1'b0 || DMemReq !== 1'b0) begin
        failures++;
        $display("FAIL %s misalign_after: mis=%b stall=%b req=%b expected 0 0 0", name, MisalignM, StallM, DMemReq);
      end
      $display("txn %s wr=%0b addr=%h misaligned", name, wr, addr);
      return;
    end
    checks++;
    if (StallM !== 1'b1 || MisalignM !== 1'b0) begin
      failures++;
      $display("FAIL %s capture: stall=%b mis=%b expected 1 0", name, StallM, MisalignM);
    end
    stalls = 1; k = 0; done = 0;
    while (!done && k < busy + 3) begin
      @(negedge clk);
      k++;
      // Fields change while stalled; the access must keep the captured values.
      MemWriteM = 1'($urandom); LoadSize = 3'($urandom); StoreSize = 2'($urandom);
      AddrM = $urandom; WriteDataM = $urandom;
      DMemAck = (k == busy);
      DMemRData = (k == busy) ? rd : $urandom;
      #1;
      if (StallM === 1'b1 && DMemReq === 1'b1) begin
        stalls++;
        checks++;
        if (DMemAddr !== {addr[31:2], 2'b00} || DMemWe !== wr || DMemBE !== exp_be ||
            (wr && DMemWData !== exp_wd) || MisalignM !== 1'b0) begin
          failures++;
          $display("FAIL %s busy: addr=%h/%h we=%b/%b be=%b/%b wd=%h/%h mis=%b (got/expected)",
                   name, DMemAddr, {addr[31:2], 2'b00}, DMemWe, wr, DMemBE, exp_be, DMemWData, exp_wd, MisalignM);
        end
      end else begin
        done = 1;
      end
    end
    DMemAck = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s no_done: still stalled after %0d cycles, expected completion", name, k);
    end
    checks++;
    if (stalls != busy + 1 || StallM !== 1'b0 || DMemReq !== 1'b0) begin
      failures++;
      $display("FAIL %s stall_count: got %0d stall=%b req=%b expected %0d 0 0", name, stalls, StallM, DMemReq, busy + 1);
    end
    checks++;
    if (LoadValidW !== !wr || BusErrM !== 1'b0 || (!wr && ReadDataW !== exp_rd)) begin
      failures++;
      $display("FAIL %s done: lv=%b berr=%b rdw=%h expected %b 0 %h", name, LoadValidW, BusErrM, ReadDataW, !wr, exp_rd);
    end
    $display("txn %s wr=%0b ls=%0d ss=%0d addr=%h busy=%0d stalls=%0d rdw=%h", name, wr, ls, ss, addr, busy, stalls, ReadDataW);
    @(negedge clk);
    MemReqM = 1'b0;
  endtask

  task automatic test_reset();
    MemWriteM = 0; LoadSize = 0; StoreSize = 0; AddrM = 0; WriteDataM = 0; DMemRData = 0;
    do_reset();
    #1;
    checks++;
    if (DMemReq !== 0 || DMemWe !== 0 || DMemBE !== 4'b0 || StallM !== 0 || LoadValidW !== 0 ||
        BusErrM !== 0 || MisalignM !== 0 || ReadDataW !== 32'd0) begin
      failures++;
      $display("FAIL reset: req=%b we=%b be=%b stall=%b lv=%b berr=%b mis=%b rdw=%h expected all 0",
               DMemReq, DMemWe, DMemBE, StallM, LoadValidW, BusErrM, MisalignM, ReadDataW);
    end
    $display("txn reset done");
  endtask

  task automatic test_ack_idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      DMemAck = 1'b1; DMemRData = $urandom | 32'h1;
      @(negedge clk);
      DMemAck = 1'b0;
      #1;
      checks++;
      if (LoadValidW !== 0 || DMemReq !== 0 || StallM !== 0 || ReadDataW !== 32'd0) begin
        failures++;
        $display("FAIL ack_idle: lv=%b req=%b stall=%b rdw=%h expected 0 0 0 0", LoadValidW, DMemReq, StallM, ReadDataW);
      end
      $display("txn ack_idle %0d", i);
    end
  endtask

  task automatic test_directed();
    @(negedge clk);
    do_txn("lb_1003", 1'b0, 3'd1, 2'd0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);
    do_txn("sh_2002", 1'b1, 3'd0, 2'd2, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 1);
    do_txn("lw_3001", 1'b0, 3'd0, 2'd0, 32'h0000_3001, 32'h0, 32'h0, 1);
    do_txn("lhu_0002", 1'b0, 3'd4, 2'd0, 32'h0000_0002, 32'h0, 32'h9ABC_0000, 5);
    do_txn("sb_0001", 1'b1, 3'd0, 2'd1, 32'h0000_0001, 32'h1234_56A5, 32'h0, 2);
    do_txn("lh_0006", 1'b0, 3'd3, 2'd0, 32'h0000_0006, 32'h0, 32'h8001_7FFF, 1);
    do_txn("ls6_0000", 1'b0, 3'd6, 2'd0, 32'h0000_0000, 32'h0, 32'hDEAD_BEEF, 1);
    do_txn("sh_0003", 1'b1, 3'd0, 2'd2, 32'h0000_0003, 32'h0, 32'h0, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      do_txn($sformatf("rand%0d", i), 1'($urandom), 3'($urandom_range(0, 7)),
             2'($urandom_range(0, 2)), a, $urandom, $urandom, $urandom_range(1, 6));
    end
  endtask

  task automatic test_timeout();
    int stalls;
    do_reset();
    MemReqM = 1'b1; MemWriteM = 1'b0; LoadSize = 3'd0; AddrM = 32'h0000_0100;
    @(negedge clk);
    ack_to = 1'b1; DMemRData = 32'hCAFE_F00D;
    @(negedge clk);
    ack_to = 1'b0;
    #1;
    checks++;
    if (to_lv !== 1'b1 || to_rdw !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL timeout_preload: lv=%b rdw=%h expected 1 cafef00d", to_lv, to_rdw);
    end
    @(negedge clk);
    AddrM = 32'h0000_0200;
    #1;
    stalls = 0;
    for (int i = 0; i < 20 && to_stall === 1'b1; i++) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (stalls != 5 || to_berr !== 1'b1 || to_rdw !== 32'd0 || to_lv !== 1'b0) begin
      failures++;
      $display("FAIL timeout: stalls=%0d berr=%b rdw=%h lv=%b expected 5 1 0 0", stalls, to_berr, to_rdw, to_lv);
    end
    @(negedge clk);
    MemReqM = 1'b0;
    #1;
    checks++;
    if (to_berr !== 1'b0 || to_req !== 1'b0 || to_stall !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle: berr=%b req=%b stall=%b expected 0 0 0", to_berr, to_req, to_stall);
    end
    $display("txn timeout stalls=%0d", stalls);
    do_reset();
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = 1'b0; LoadSize = 3'd0; AddrM = 32'h0000_0040;
    @(negedge clk);
    #1;
    checks++;
    if (DMemReq !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy_req: req=%b expected 1", DMemReq);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; MemReqM = 1'b0;
    #1;
    checks++;
    if (DMemReq !== 1'b0 || StallM !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_drop: req=%b stall=%b expected 0 0", DMemReq, StallM);
    end
    DMemAck = 1'b1; DMemRData = 32'h1234_5678;
    @(negedge clk);
    DMemAck = 1'b0;
    #1;
    checks++;
    if (LoadValidW !== 1'b0 || DMemReq !== 1'b0 || ReadDataW !== 32'd0) begin
      failures++;
      $display("FAIL reset_busy_late_ack: lv=%b req=%b rdw=%h expected 0 0 0", LoadValidW, DMemReq, ReadDataW);
    end
    $display("txn reset_busy done");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    do_txn("b2b_sw", 1'b1, 3'd0, 2'd0, 32'h0000_0800, 32'h0BAD_F00D, 32'h0, 1);
    do_txn("b2b_lbu", 1'b0, 3'd2, 2'd0, 32'h0000_0801, 32'h0, 32'h0000_F700, 1);
    do_txn("b2b_lw", 1'b0, 3'd0, 2'd0, 32'h0000_0804, 32'h0, 32'h0BAD_F00D, 3);
  endtask

  initial begin
    reset = 1'b1;
    MemReqM = 1'b0;
    DMemAck = 1'b0;
    ack_to = 1'b0;
    test_reset();
    test_ack_idle();
    test_directed();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
